// File: rtl/toggle_reg_arbiter.sv
// ----------------------------------------------------------------------------
// toggle_reg_arbiter
//   Shares one W-bit register among N_REQ requesters. A round-robin arbiter
//   picks one requester at a time; the winner's op (hold, load, inverted
//   load, clear) is applied to the register and acknowledged with a
//   one-cycle pulse. A served requester must drop its request before the
//   arbiter returns to IDLE, so each request pulse yields exactly one op.
//
// Ports
//   clk       in   1              system clock, rising edge
//   rst_n     in   1              asynchronous reset, active-low
//   req       in   N_REQ          request level per requester
//   op        in   2*N_REQ        op[2i+1:2i]: 00 hold, 01 load, 10 inv-load, 11 clear
//   wdata     in   W*N_REQ        wdata[W*i+:W] operand for requester i
//   ack       out  N_REQ          one-hot, one-cycle completion pulse
//   grant_id  out  GW             index of current/last winner
//   busy      out  1              high in any state except IDLE
//   reg_out   out  W              shared register value
//   op_count  out  16             completed ops, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module toggle_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   op,
  input  logic [W*N_REQ-1:0]   wdata,
  output logic [N_REQ-1:0]     ack,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic [W-1:0]         reg_out,
  output logic [15:0]          op_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    EXEC      = 2'b01,
    ACK       = 2'b10,
    WAIT_DROP = 2'b11
  } state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t             state_r;
  logic [GW-1:0]      last_ptr_r;
  logic [1:0]         op_r;
  logic [W-1:0]       wdata_r;

  logic [GW:0]        pick_s;
  logic               pick_valid_s;
  logic [GW-1:0]      pick_idx_s;
  logic [1:0]         op_sel_s;
  logic [W-1:0]       wdata_sel_s;
  logic [N_REQ-1:0]   ack_onehot_s;
  logic               req_granted_s;

  // Round-robin pick: returns {found, index} of the first set request
  // searching upward from last+1 with wrap. The loop runs from the farthest
  // candidate to the nearest so the nearest set request is the one kept.
  function automatic logic [GW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input logic [GW-1:0]    last);
    logic [GW:0]   res;
    logic [GW-1:0] cand_idx;
    int            cand;
    res = {(GW+1){1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      cand     = (int'(last) + k) % N_REQ;
      cand_idx = GW'(cand);
      if (r[cand_idx]) begin
        res = {1'b1, cand_idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration result and operand mux for the current winner candidate.
  always_comb begin
    pick_s       = rr_pick(req, last_ptr_r);
    pick_valid_s = pick_s[GW];
    pick_idx_s   = pick_s[GW-1:0];
    op_sel_s     = 2'b00;
    wdata_sel_s  = {W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx_s == GW'(i)) begin
        op_sel_s    = op[2*i +: 2];
        wdata_sel_s = wdata[W*i +: W];
      end else begin
        op_sel_s    = op_sel_s;
        wdata_sel_s = wdata_sel_s;
      end
    end
  end

  // One-hot ack pattern and request level for the latched winner.
  always_comb begin
    ack_onehot_s  = {N_REQ{1'b0}};
    req_granted_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        ack_onehot_s[i] = 1'b1;
        req_granted_s   = req[i];
      end else begin
        ack_onehot_s[i] = 1'b0;
        req_granted_s   = req_granted_s;
      end
    end
  end

  // Control FSM with registered outputs and the shared register itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_ptr_r <= GW'(N_REQ - 1);
      op_r       <= 2'b00;
      wdata_r    <= {W{1'b0}};
      ack        <= {N_REQ{1'b0}};
      grant_id   <= {GW{1'b0}};
      busy       <= 1'b0;
      reg_out    <= {W{1'b0}};
      op_count   <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            // op and wdata are captured here; later changes are ignored
            grant_id <= pick_idx_s;
            op_r     <= op_sel_s;
            wdata_r  <= wdata_sel_s;
            busy     <= 1'b1;
            state_r  <= EXEC;
          end else begin
            state_r  <= IDLE;
          end
        end
        EXEC: begin
          case (op_r)
            OP_HOLD:  reg_out <= reg_out;
            OP_LOAD:  reg_out <= wdata_r;
            OP_INV:   reg_out <= ~wdata_r;
            OP_CLEAR: reg_out <= {W{1'b0}};
            default:  reg_out <= reg_out;
          endcase
          if (op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
          end else begin
            op_count <= op_count;
          end
          ack     <= ack_onehot_s;
          state_r <= ACK;
        end
        ACK: begin
          ack        <= {N_REQ{1'b0}};
          last_ptr_r <= grant_id;
          state_r    <= WAIT_DROP;
        end
        WAIT_DROP: begin
          // the served requester must release before anyone is re-arbitrated
          if (!req_granted_s) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_DROP;
          end
        end
        default: begin
          ack     <= {N_REQ{1'b0}};
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_toggle_reg_arbiter
//   Directed self-checking bench for toggle_reg_arbiter (N_REQ=4, W=8).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at the same point, so each check sees the state after that edge.
// ----------------------------------------------------------------------------
module tb_toggle_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  reg_out;
  logic [15:0] op_count;

  int checks;
  int errors;

  toggle_reg_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .op       (op),
    .wdata    (wdata),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .reg_out  (reg_out),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for any ack pulse; returns 0 if none within the budget.
  task automatic wait_ack(output logic [3:0] a);
    a = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ack != 4'b0000) begin
        a = ack;
        break;
      end
    end
  endtask

  // Single isolated request with cycle-exact latency checks.
  task automatic serve(input int idx, input logic [1:0] opv, input logic [7:0] wd,
                       input logic [7:0] exp_reg, input logic [15:0] exp_cnt);
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << idx;
    req[idx]           = 1'b1;
    op[2*idx +: 2]     = opv;
    wdata[8*idx +: 8]  = wd;
    tick();
    chk("grant_busy", 32'(busy), 32'(1'b1));
    chk("grant_id", 32'(grant_id), 32'(idx));
    chk("ack_before", 32'(ack), 32'(4'b0000));
    op    = ~op;
    wdata = ~wdata;
    tick();
    chk("ack_pulse", 32'(ack), 32'(exp_ack));
    chk("reg_out", 32'(reg_out), 32'(exp_reg));
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    tick();
    chk("ack_fall", 32'(ack), 32'(4'b0000));
    req[idx] = 1'b0;
    tick();
    chk("busy_drop", 32'(busy), 32'(1'b0));
  endtask

  initial begin : stim
    logic [3:0] a;
    logic [3:0] exp_a;
    int         gcount;
    int         acks_seen;
    int         tmr [4];
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    op     = 8'h00;
    wdata  = 32'h0000_0000;

    // Power-on reset values
    tick();
    tick();
    chk("rst_reg", 32'(reg_out), 32'(8'h00));
    chk("rst_ack", 32'(ack), 32'(4'b0000));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_gid", 32'(grant_id), 32'(2'd0));
    chk("rst_cnt", 32'(op_count), 32'(16'h0000));
    rst_n = 1'b1;
    tick();

    // Load then inverted load from requester 0
    serve(0, 2'b01, 8'hA5, 8'hA5, 16'd1);
    serve(0, 2'b10, 8'h0F, 8'hF0, 16'd2);

    // Mid-run reset held for one cycle
    rst_n = 1'b0;
    #1;
    chk("mid_rst_reg", 32'(reg_out), 32'(8'h00));
    chk("mid_rst_cnt", 32'(op_count), 32'(16'h0000));
    chk("mid_rst_busy", 32'(busy), 32'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();

    // All four requesting; each drops 1 cycle after ack, re-raises 2 later
    op     = 8'b01_01_01_01;
    wdata  = {8'h44, 8'h33, 8'h22, 8'h11};
    req    = 4'b1111;
    gcount = 0;
    for (int i = 0; i < 4; i++) tmr[i] = 0;
    for (int c = 0; c < 200 && gcount < 6; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (tmr[i] > 0) begin
          tmr[i]++;
          if (tmr[i] == 2) req[i] = 1'b0;
          else if (tmr[i] == 4) begin
            req[i] = 1'b1;
            tmr[i] = 0;
          end
        end
      end
      if (ack != 4'b0000) begin
        exp_a = 4'b0001 << (gcount % 4);
        chk("rr_order", 32'(ack), 32'(exp_a));
        chk("rr_reg", 32'(reg_out), 32'(8'h11 * ((gcount % 4) + 1)));
        tmr[gcount % 4] = 1;
        gcount++;
      end
    end
    chk("rr_grants", 32'(gcount), 32'(6));
    req = 4'b0000;
    tick();
    tick();
    tick();
    chk("rr_count", 32'(op_count), 32'(16'd6));
    chk("rr_idle", 32'(busy), 32'(1'b0));

    // Requester 0 holds after ack; requester 1 waits until 0 releases
    op    = 8'b00_00_10_01;
    wdata = {8'h00, 8'h00, 8'h3C, 8'h5A};
    req   = 4'b0001;
    wait_ack(a);
    chk("hold_ack0", 32'(a), 32'(4'b0001));
    chk("hold_reg0", 32'(reg_out), 32'(8'h5A));
    req = 4'b0011;
    acks_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack != 4'b0000) acks_seen++;
    end
    chk("hold_no_reack", 32'(acks_seen), 32'(0));
    chk("hold_busy", 32'(busy), 32'(1'b1));
    req = 4'b0010;
    wait_ack(a);
    chk("hold_ack1", 32'(a), 32'(4'b0010));
    chk("hold_reg1", 32'(reg_out), 32'(8'hC3));
    req = 4'b0001;
    wait_ack(a);
    chk("hold_reack0", 32'(a), 32'(4'b0001));
    chk("hold_reg0b", 32'(reg_out), 32'(8'h5A));
    req = 4'b0000;
    tick();
    tick();
    tick();

    // Reset during EXEC of a clear from requester 2
    op    = 8'b00_11_01_00;
    wdata = {8'h00, 8'h00, 8'h77, 8'h00};
    req   = 4'b0100;
    tick();
    chk("abort_gid", 32'(grant_id), 32'(2'd2));
    chk("abort_busy", 32'(busy), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("abort_ack", 32'(ack), 32'(4'b0000));
    chk("abort_reg", 32'(reg_out), 32'(8'h00));
    chk("abort_busy0", 32'(busy), 32'(1'b0));
    tick();
    rst_n = 1'b1;
    req   = 4'b0110;
    wait_ack(a);
    chk("abort_next", 32'(a), 32'(4'b0010));
    chk("abort_next_reg", 32'(reg_out), 32'(8'h77));
    req = 4'b0000;
    tick();
    tick();
    tick();

    // Saturation of op_count, preloaded to FFFE
    op    = 8'h00;
    wdata = 32'h0000_0000;
    force dut.op_count = 16'hFFFE;
    tick();
    release dut.op_count;
    tick();
    chk("sat_preload", 32'(op_count), 32'(16'hFFFE));
    serve(0, 2'b01, 8'h12, 8'h12, 16'hFFFF);
    serve(0, 2'b10, 8'h12, 8'hED, 16'hFFFF);
    serve(0, 2'b00, 8'h99, 8'hED, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
